full_adder_dataflow: RTL and testbench

- Dataflow-style full adder built from a chain of WIDTH one-bit full-adder cells. Each cell uses only continuous-assignment logic equations.
- The result can be captured in an output register clocked by clk.
- Used as a leaf arithmetic primitive. The default configuration is a single-bit adder with registered sum and carry-out.

---
 rtl/full_adder_dataflow.sv | 72 +++++++
 tb/tb_full_adder_dataflow.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_dataflow.sv
// Ripple-carry adder built from WIDTH one-bit dataflow full-adder cells; {cout,sum} = a + b + cin.
// Latency: 1 clk when OUT_REG=1 (async active-low clear), 0 (purely combinational) when OUT_REG=0.
// Backpressure: none; a new result is accepted and produced every cycle.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and the carry equations.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module full_adder_dataflow #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // One cell per bit, chained through c[] (ripple carry).
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  if (OUT_REG) begin : g_reg
    // Capture the settled sum and carry-out each edge; reset clears immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum  <= '0;
        cout <= 1'b0;
      end else begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end else begin : g_comb
    assign sum  = s;
    assign cout = c[WIDTH];

    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

endmodule

// File: tb/tb_full_adder_dataflow.sv
// Bench for full_adder_dataflow: four builds (1/8 bit, registered/combinational) share stimulus.
// Registered builds are compared against a one-cycle-delayed arithmetic model on every falling edge.
// Directed literal checks pin reset, the truth table, carry ripple and mid-stream reset.

module tb_full_adder_dataflow;

  logic clk;
  logic rst_n;

  logic       a1, b1, cin1;
  logic [7:0] a8, b8;
  logic       cin8;

  logic       sum_w1r, cout_w1r, sum_w1c, cout_w1c;
  logic [7:0] sum_w8r, sum_w8c;
  logic       cout_w8r, cout_w8c;

  int n_chk;
  int n_fail;
  bit chk_en;

  // Expected registered results: arithmetic sum of the inputs seen at the last edge.
  logic [1:0] exp1;
  logic [8:0] exp8;

  full_adder_dataflow #(.WIDTH(1), .OUT_REG(1'b1)) u_w1r (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .sum(sum_w1r), .cout(cout_w1r));
  full_adder_dataflow #(.WIDTH(1), .OUT_REG(1'b0)) u_w1c (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .sum(sum_w1c), .cout(cout_w1c));
  full_adder_dataflow #(.WIDTH(8), .OUT_REG(1'b1)) u_w8r (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(sum_w8r), .cout(cout_w8r));
  full_adder_dataflow #(.WIDTH(8), .OUT_REG(1'b0)) u_w8c (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(sum_w8c), .cout(cout_w8c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result of a+b+cin one edge later, cleared while reset is low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp1 <= 2'd0;
      exp8 <= 9'd0;
    end else begin
      exp1 <= 2'({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
      exp8 <= {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
    end
  end

  // Continuous compare of all four builds away from the active edge.
  always @(negedge clk) begin
    logic [1:0] live1;
    logic [8:0] live8;
    if (chk_en) begin
      live1 = 2'({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
      live8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      chk("w1_reg_model", 33'({cout_w1r, sum_w1r}), 33'(exp1));
      chk("w8_reg_model", 33'({cout_w8r, sum_w8r}), 33'(exp8));
      chk("w1_comb_model", 33'({cout_w1c, sum_w1c}), 33'(live1));
      chk("w8_comb_model", 33'({cout_w8c, sum_w8c}), 33'(live8));
    end
  end

  initial begin
    logic [7:0] sum_tab;
    logic [7:0] cout_tab;
    logic [2:0] v;
    logic [1:0] want;
    sum_tab  = 8'b1001_0110;
    cout_tab = 8'b1110_1000;
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst_n  = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

    // Reset state, asserted before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_w1", 33'({cout_w1r, sum_w1r}), 33'd0);
    chk("reset_w8", 33'({cout_w8r, sum_w8r}), 33'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;

    // First edge after release captures a=b=cin=1.
    @(posedge clk); #1;
    chk("w1_after_release", 33'({cout_w1r, sum_w1r}), 33'h3);
    chk("w8_after_release", 33'({cout_w8r, sum_w8r}), 33'h0);

    // Mid-cycle reset drops outputs without a clock edge.
    #5 rst_n = 1'b0;
    #1;
    chk("w1_async_reset", 33'({cout_w1r, sum_w1r}), 33'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("w1_reset_recover", 33'({cout_w1r, sum_w1r}), 33'h3);

    // Combinational truth table, each case held 20 time units.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      v = 3'(i);
      {a1, b1, cin1} = v;
      #20;
      chk("truth_table", 33'({cout_w1c, sum_w1c}), 33'({cout_tab[i], sum_tab[i]}));
    end

    // Registered latency: old result until the edge, new result right after it.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      v = 3'(i);
      {a1, b1, cin1} = v;
      #1;
      if (i > 0) begin
        want = {cout_tab[i-1], sum_tab[i-1]};
        chk("reg_hold_prev", 33'({cout_w1r, sum_w1r}), 33'(want));
      end
      @(posedge clk); #1;
      chk("reg_latency", 33'({cout_w1r, sum_w1r}), 33'({cout_tab[i], sum_tab[i]}));
    end

    // Full carry ripple on the 8-bit builds.
    @(posedge clk); #2;
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    #1 chk("ripple_ff_00_1", 33'({cout_w8c, sum_w8c}), 33'h100);
    #1 a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    #1 chk("ones_ones_1", 33'({cout_w8c, sum_w8c}), 33'h1FF);
    @(posedge clk); #1;
    chk("ones_ones_1_reg", 33'({cout_w8r, sum_w8r}), 33'h1FF);
    #1 a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    #1 chk("all_zero_comb", 33'({cout_w8c, sum_w8c}), 33'h0);
    @(posedge clk); #1;
    chk("all_zero_reg", 33'({cout_w8r, sum_w8r}), 33'h0);

    // Random traffic, one new vector per cycle, checked by the compare process.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1));
      a1   = 1'($urandom_range(0, 1));
      b1   = 1'($urandom_range(0, 1));
      cin1 = 1'($urandom_range(0, 1));
    end

    // Mid-stream reset on the 8-bit registered build.
    @(posedge clk); #2;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_80_80", 33'({cout_w8r, sum_w8r}), 33'h100);
    #1 rst_n = 1'b0;
    #1 chk("w8_async_reset", 33'({cout_w8r, sum_w8r}), 33'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("w8_reset_recover", 33'({cout_w8r, sum_w8r}), 33'h100);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
